// File: rtl/instr_fetch_unit.sv
// 6502 instruction fetch: reads opcode plus 0-2 operand bytes, decodes the
// addressing mode and length, and hands the bundle downstream via valid/ack.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | no fetch in progress, waiting for fetch_en
// FETCH_OP | reading the opcode byte at pc
// FETCH_LO | reading the first operand byte
// FETCH_HI | reading the second operand byte
// VALID    | bundle presented, waiting for instr_ack
// ERROR    | memory never answered; held until pc_load or reset
module instr_fetch_unit #(
    parameter logic [15:0] RESET_PC     = 16'h0200,
    parameter int          WAIT_TIMEOUT = 0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        fetch_en,
    input  logic        pc_load,
    input  logic [15:0] pc_in,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ready,
    output logic [7:0]  opcode,
    output logic [7:0]  operand_lo,
    output logic [7:0]  operand_hi,
    output logic [3:0]  addr_mode,
    output logic [1:0]  instr_len,
    output logic [15:0] instr_pc,
    output logic [15:0] pc_next,
    output logic        instr_valid,
    input  logic        instr_ack,
    output logic        bus_error
);

    typedef enum logic [2:0] {
        IDLE, FETCH_OP, FETCH_LO, FETCH_HI, VALID, ERROR
    } state_t;

    localparam logic [3:0] M_IMM  = 4'd0,  M_ZP   = 4'd1,  M_ZPX  = 4'd2;
    localparam logic [3:0] M_ZPY  = 4'd3,  M_ABS  = 4'd4,  M_ABSX = 4'd5;
    localparam logic [3:0] M_ABSY = 4'd6,  M_IND  = 4'd7,  M_INDX = 4'd8;
    localparam logic [3:0] M_INDY = 4'd9,  M_REL  = 4'd10, M_ACC  = 4'd11;
    localparam logic [3:0] M_IMPL = 4'd12;

    // Wait timer is a down-counter: loaded with WAIT_TIMEOUT-1, expires at zero.
    localparam int            CW        = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT) : 1;
    localparam logic [CW-1:0] WAIT_LOAD = CW'((WAIT_TIMEOUT > 0) ? WAIT_TIMEOUT - 1 : 0);

    state_t        state;
    logic [15:0]   pc;
    logic [CW-1:0] wait_cnt;
    logic [3:0]    dec_mode;
    logic [1:0]    dec_len;
    logic          fetching;
    logic          timed_out;

    function automatic logic [3:0] decode_mode(input logic [7:0] op);
        logic [2:0] bbb;
        logic [1:0] cc;
        bbb = op[4:2];
        cc  = op[1:0];
        decode_mode = M_IMPL;
        case (cc)
            2'b01: begin
                case (bbb)
                    3'd0: decode_mode = M_INDX;
                    3'd1: decode_mode = M_ZP;
                    3'd2: decode_mode = M_IMM;
                    3'd3: decode_mode = M_ABS;
                    3'd4: decode_mode = M_INDY;
                    3'd5: decode_mode = M_ZPX;
                    3'd6: decode_mode = M_ABSY;
                    default: decode_mode = M_ABSX;
                endcase
            end
            2'b10: begin
                case (bbb)
                    3'd0: decode_mode = M_IMM;
                    3'd1: decode_mode = M_ZP;
                    3'd2: decode_mode = op[7] ? M_IMPL : M_ACC;
                    3'd3: decode_mode = M_ABS;
                    3'd5: decode_mode = (op == 8'h96 || op == 8'hB6) ? M_ZPY : M_ZPX;
                    3'd7: decode_mode = (op == 8'hBE) ? M_ABSY : M_ABSX;
                    default: decode_mode = M_IMPL;
                endcase
            end
            2'b00: begin
                case (bbb)
                    3'd0: begin
                        if (op == 8'h20)
                            decode_mode = M_ABS;
                        else if (op == 8'h00 || op == 8'h40 || op == 8'h60)
                            decode_mode = M_IMPL;
                        else
                            decode_mode = M_IMM;
                    end
                    3'd1: decode_mode = M_ZP;
                    3'd3: decode_mode = (op == 8'h6C) ? M_IND : M_ABS;
                    3'd4: decode_mode = M_REL;
                    3'd5: decode_mode = M_ZPX;
                    3'd7: decode_mode = M_ABSX;
                    default: decode_mode = M_IMPL;
                endcase
            end
            default: decode_mode = M_IMPL;
        endcase
    endfunction

    function automatic logic [1:0] mode_len(input logic [3:0] mode);
        case (mode)
            M_ABS, M_ABSX, M_ABSY, M_IND: mode_len = 2'd3;
            M_ACC, M_IMPL:                mode_len = 2'd1;
            default:                      mode_len = 2'd2;
        endcase
    endfunction

    always_comb begin
        dec_mode = decode_mode(mem_rdata);
        dec_len  = mode_len(dec_mode);
    end

    assign fetching  = (state == FETCH_OP) || (state == FETCH_LO) || (state == FETCH_HI);
    assign timed_out = (WAIT_TIMEOUT > 0) && (wait_cnt == '0);
    assign mem_addr  = pc;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            wait_cnt    <= WAIT_LOAD;
            mem_rd      <= 1'b0;
            instr_valid <= 1'b0;
            bus_error   <= 1'b0;
            opcode      <= 8'h00;
            operand_lo  <= 8'h00;
            operand_hi  <= 8'h00;
            instr_pc    <= 16'h0000;
            pc_next     <= 16'h0000;
            addr_mode   <= M_IMPL;
            instr_len   <= 2'd1;
        end else if (pc_load) begin
            // Redirect abandons any in-flight read and any pending bundle.
            state       <= IDLE;
            pc          <= pc_in;
            wait_cnt    <= WAIT_LOAD;
            mem_rd      <= 1'b0;
            instr_valid <= 1'b0;
            bus_error   <= 1'b0;
        end else begin
            if (!fetching || mem_ready)
                wait_cnt <= WAIT_LOAD;
            else if (wait_cnt != '0)
                wait_cnt <= wait_cnt - CW'(1);

            if (fetching && mem_ready)
                pc <= pc + 16'd1;

            case (state)
                IDLE: begin
                    if (fetch_en) begin
                        state    <= FETCH_OP;
                        instr_pc <= pc;
                        mem_rd   <= 1'b1;
                    end
                end
                FETCH_OP: begin
                    if (mem_ready) begin
                        opcode     <= mem_rdata;
                        addr_mode  <= dec_mode;
                        instr_len  <= dec_len;
                        pc_next    <= instr_pc + 16'(dec_len);
                        operand_lo <= 8'h00;
                        operand_hi <= 8'h00;
                        if (dec_len == 2'd1) begin
                            state       <= VALID;
                            instr_valid <= 1'b1;
                            mem_rd      <= 1'b0;
                        end else begin
                            state <= FETCH_LO;
                        end
                    end else if (timed_out) begin
                        state     <= ERROR;
                        mem_rd    <= 1'b0;
                        bus_error <= 1'b1;
                    end
                end
                FETCH_LO: begin
                    if (mem_ready) begin
                        operand_lo <= mem_rdata;
                        if (instr_len == 2'd2) begin
                            state       <= VALID;
                            instr_valid <= 1'b1;
                            mem_rd      <= 1'b0;
                        end else begin
                            state <= FETCH_HI;
                        end
                    end else if (timed_out) begin
                        state     <= ERROR;
                        mem_rd    <= 1'b0;
                        bus_error <= 1'b1;
                    end
                end
                FETCH_HI: begin
                    if (mem_ready) begin
                        operand_hi  <= mem_rdata;
                        state       <= VALID;
                        instr_valid <= 1'b1;
                        mem_rd      <= 1'b0;
                    end else if (timed_out) begin
                        state     <= ERROR;
                        mem_rd    <= 1'b0;
                        bus_error <= 1'b1;
                    end
                end
                VALID: begin
                    if (instr_ack) begin
                        instr_valid <= 1'b0;
                        if (fetch_en) begin
                            state    <= FETCH_OP;
                            instr_pc <= pc;
                            mem_rd   <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                ERROR: begin
                    mem_rd <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: random memory image and stalls, bundles checked
// against a table-driven 6502 decode model; second instance covers the timeout.
module tb_instr_fetch_unit;

    logic        clk;
    logic        reset_n;
    logic        fetch_en, pc_load, instr_ack, mem_ready;
    logic [15:0] pc_in;
    logic [7:0]  mem_rdata;
    logic [15:0] mem_addr, instr_pc, pc_next;
    logic        mem_rd, instr_valid, bus_error;
    logic [7:0]  opcode, operand_lo, operand_hi;
    logic [3:0]  addr_mode;
    logic [1:0]  instr_len;

    logic        t_fetch_en, t_pc_load, t_instr_ack, t_mem_ready;
    logic [15:0] t_pc_in;
    logic [7:0]  t_mem_rdata;
    logic [15:0] t_mem_addr, t_instr_pc, t_pc_next;
    logic        t_mem_rd, t_instr_valid, t_bus_error;
    logic [7:0]  t_opcode, t_operand_lo, t_operand_hi;
    logic [3:0]  t_addr_mode;
    logic [1:0]  t_instr_len;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  mem [0:65535];
    logic [15:0] rd_log [$];
    logic [15:0] mpc;
    int          stall_max = 0;
    int          lat;

    instr_fetch_unit dut (
        .clk(clk), .reset_n(reset_n), .fetch_en(fetch_en), .pc_load(pc_load),
        .pc_in(pc_in), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .opcode(opcode), .operand_lo(operand_lo),
        .operand_hi(operand_hi), .addr_mode(addr_mode), .instr_len(instr_len),
        .instr_pc(instr_pc), .pc_next(pc_next), .instr_valid(instr_valid),
        .instr_ack(instr_ack), .bus_error(bus_error)
    );

    instr_fetch_unit #(.WAIT_TIMEOUT(4)) dut_to (
        .clk(clk), .reset_n(reset_n), .fetch_en(t_fetch_en), .pc_load(t_pc_load),
        .pc_in(t_pc_in), .mem_addr(t_mem_addr), .mem_rd(t_mem_rd), .mem_rdata(t_mem_rdata),
        .mem_ready(t_mem_ready), .opcode(t_opcode), .operand_lo(t_operand_lo),
        .operand_hi(t_operand_hi), .addr_mode(t_addr_mode), .instr_len(t_instr_len),
        .instr_pc(t_instr_pc), .pc_next(t_pc_next), .instr_valid(t_instr_valid),
        .instr_ack(t_instr_ack), .bus_error(t_bus_error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // 6502 mode from the opcode: named exceptions first, then per-column tables.
    function automatic int model_mode(input logic [7:0] op);
        int a, b, c;
        int t01 [8];
        int t10 [8];
        int t00 [8];
        a = int'(op) / 32;
        b = (int'(op) / 4) % 8;
        c = int'(op) % 4;
        t01 = '{8, 1, 0, 4, 9, 2, 6, 5};
        t10 = '{0, 1, (a < 4) ? 11 : 12, 4, 12, 2, 12, 5};
        t00 = '{0, 1, 12, 4, 10, 2, 12, 5};
        case (op)
            8'h96, 8'hB6:        return 3;
            8'hBE:               return 6;
            8'h6C:               return 7;
            8'h20:               return 4;
            8'h00, 8'h40, 8'h60: return 12;
            default: ;
        endcase
        if (c == 1) return t01[b];
        if (c == 2) return t10[b];
        if (c == 0) return t00[b];
        return 12;
    endfunction

    function automatic int model_len(input int mode);
        if (mode >= 4 && mode <= 7) return 3;
        if (mode >= 11) return 1;
        return 2;
    endfunction

    // Memory responder: random stalls, logs accepted reads, checks address hold.
    initial begin
        int          stall_left;
        logic        prev_rd, prev_ready;
        logic [15:0] prev_addr;
        stall_left = 0;
        prev_rd = 1'b0;
        prev_ready = 1'b0;
        prev_addr = '0;
        mem_ready = 1'b0;
        mem_rdata = 8'h00;
        forever begin
            @(negedge clk);
            if (prev_rd && prev_ready && !pc_load && reset_n)
                rd_log.push_back(prev_addr);
            if (prev_rd && !prev_ready && !pc_load && mem_rd && reset_n)
                check("addr_stable", 32'(mem_addr), 32'(prev_addr));
            if (mem_rd) begin
                if (stall_left > 0) begin
                    mem_ready = 1'b0;
                    mem_rdata = 8'($urandom);
                    stall_left--;
                end else begin
                    mem_ready = 1'b1;
                    mem_rdata = mem[mem_addr];
                    stall_left = $urandom_range(0, stall_max);
                end
            end else begin
                mem_ready = 1'($urandom_range(0, 1));
                mem_rdata = 8'($urandom);
            end
            prev_rd = mem_rd;
            prev_ready = mem_ready;
            prev_addr = mem_addr;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic redirect(input logic [15:0] a);
        tick();
        pc_load = 1'b1;
        pc_in = a;
        tick();
        pc_load = 1'b0;
        rd_log.delete();
        mpc = a;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mem_rd"}, 32'(mem_rd), 0);
        check({tag, "_mem_addr"}, 32'(mem_addr), 32'h0200);
        check({tag, "_valid"}, 32'(instr_valid), 0);
        check({tag, "_bus_error"}, 32'(bus_error), 0);
        check({tag, "_opcode"}, 32'(opcode), 0);
        check({tag, "_lo"}, 32'(operand_lo), 0);
        check({tag, "_hi"}, 32'(operand_hi), 0);
        check({tag, "_instr_pc"}, 32'(instr_pc), 0);
        check({tag, "_pc_next"}, 32'(pc_next), 0);
        check({tag, "_mode"}, 32'(addr_mode), 12);
        check({tag, "_len"}, 32'(instr_len), 1);
        check({tag, "_t_state"}, {t_mem_rd, t_instr_valid, t_bus_error, t_mem_addr},
              {3'b000, 16'h0200});
        check({tag, "_t_bundle"}, {t_opcode, t_operand_lo, t_operand_hi, t_addr_mode, t_instr_len},
              {24'h0, 4'd12, 2'd1});
        check({tag, "_t_pcs"}, {t_instr_pc, t_pc_next}, 0);
    endtask

    // Waits for the bundle at mpc, checks it and the read addresses, then acks.
    task automatic run_instr(input bit may_idle, output int latency);
        logic [15:0] p, nxt;
        logic [7:0]  op, lo, hi;
        int          mode, len;
        bit          got;
        p = mpc;
        op = mem[p];
        mode = model_mode(op);
        len = model_len(mode);
        lo = (len > 1) ? mem[16'(p + 1)] : 8'h00;
        hi = (len > 2) ? mem[16'(p + 2)] : 8'h00;
        nxt = 16'(p + len);
        latency = 0;
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            latency++;
            if (instr_valid) begin
                got = 1'b1;
                break;
            end
        end
        check("valid_seen", 32'(got), 1);
        if (!got) return;
        check("opcode", 32'(opcode), 32'(op));
        check("addr_mode", 32'(addr_mode), 32'(mode));
        check("instr_len", 32'(instr_len), 32'(len));
        check("operand_lo", 32'(operand_lo), 32'(lo));
        check("operand_hi", 32'(operand_hi), 32'(hi));
        check("instr_pc", 32'(instr_pc), 32'(p));
        check("pc_next", 32'(pc_next), 32'(nxt));
        check("rd_count", 32'(rd_log.size()), 32'(len));
        for (int i = 0; i < len; i++)
            if (rd_log.size() > 0)
                check("rd_addr", 32'(rd_log.pop_front()), 32'(16'(p + i)));
        repeat ($urandom_range(0, 3)) begin
            tick();
            check("valid_hold", 32'(instr_valid), 1);
            check("hold_opcode", 32'(opcode), 32'(op));
        end
        if (may_idle && $urandom_range(0, 3) == 0) fetch_en = 1'b0;
        instr_ack = 1'b1;
        tick();
        instr_ack = 1'b0;
        check("valid_drop", 32'(instr_valid), 0);
        if (!fetch_en) begin
            repeat ($urandom_range(0, 2)) tick();
            fetch_en = 1'b1;
        end
        mpc = nxt;
    endtask

    initial begin
        reset_n = 1'b0;
        fetch_en = 1'b0;
        pc_load = 1'b0;
        pc_in = '0;
        instr_ack = 1'b0;
        t_fetch_en = 1'b0;
        t_pc_load = 1'b0;
        t_pc_in = '0;
        t_instr_ack = 1'b0;
        t_mem_ready = 1'b0;
        t_mem_rdata = 8'h00;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        mem[16'h0200] = 8'hA9; mem[16'h0201] = 8'h42;
        mem[16'h0300] = 8'h6C; mem[16'h0301] = 8'hFF; mem[16'h0302] = 8'h30;
        mem[16'h0400] = 8'h96; mem[16'h0402] = 8'hBE; mem[16'h0405] = 8'h0A;
        mem[16'h0406] = 8'hEA; mem[16'h0407] = 8'hD0; mem[16'h0409] = 8'hB1;
        mem[16'h0500] = 8'hAD; mem[16'h8000] = 8'hE8; mem[16'hFFFF] = 8'hA5;
        mpc = 16'h0200;

        #12;
        check_reset_outputs("reset");
        tick();
        reset_n = 1'b1;

        // LDA #$42: two-byte read from reset PC, valid three edges after fetch_en
        tick();
        fetch_en = 1'b1;
        run_instr(1'b0, lat);
        check("lat_2byte", 32'(lat), 3);

        // JMP ($30FF) from IDLE: valid on the fourth edge
        fetch_en = 1'b0;
        redirect(16'h0300);
        fetch_en = 1'b1;
        run_instr(1'b0, lat);
        check("lat_3byte", 32'(lat), 4);

        // ZPY, ABSY, ACC, IMPL, REL, INDY back to back
        redirect(16'h0400);
        for (int i = 0; i < 6; i++) run_instr(1'b0, lat);

        // redirect while the high operand byte is being read
        fetch_en = 1'b0;
        redirect(16'h0500);
        fetch_en = 1'b1;
        repeat (3) tick();
        check("abort_in_hi_reads", 32'(rd_log.size()), 2);
        check("abort_in_hi_rd", 32'(mem_rd), 1);
        redirect(16'h8000);
        check("abort_no_valid", 32'(instr_valid), 0);
        run_instr(1'b0, lat);

        // operand read wraps from $FFFF to $0000
        redirect(16'hFFFF);
        run_instr(1'b0, lat);

        // ack together with redirect: redirect wins, bundle consumed
        redirect(16'h0200);
        for (int i = 0; i < 50 && !instr_valid; i++) tick();
        check("ackload_valid", 32'(instr_valid), 1);
        instr_ack = 1'b1;
        pc_load = 1'b1;
        pc_in = 16'h0300;
        tick();
        instr_ack = 1'b0;
        pc_load = 1'b0;
        rd_log.delete();
        mpc = 16'h0300;
        check("ackload_drop", 32'(instr_valid), 0);
        run_instr(1'b0, lat);

        // random instruction stream with stalls and idle gaps
        stall_max = 5;
        for (int i = 0; i < 40; i++) begin
            if (i % 10 == 0) redirect(16'($urandom));
            run_instr(1'b1, lat);
        end

        // timeout instance: mem_ready stuck low
        tick();
        t_fetch_en = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (k <= 4) begin
                check("to_waiting_rd", 32'(t_mem_rd), 1);
                check("to_waiting_err", 32'(t_bus_error), 0);
            end else begin
                check("to_err_set", 32'(t_bus_error), 1);
                check("to_err_rd", 32'(t_mem_rd), 0);
            end
        end
        t_fetch_en = 1'b0;
        repeat (3) tick();
        check("to_err_sticky", {t_bus_error, t_mem_rd}, 2'b10);
        t_pc_load = 1'b1;
        t_pc_in = 16'h1234;
        tick();
        t_pc_load = 1'b0;
        check("to_err_clear", 32'(t_bus_error), 0);
        check("to_redirect_addr", 32'(t_mem_addr), 32'h1234);
        t_fetch_en = 1'b1;

        // asynchronous reset in the middle of a fetch
        redirect(16'h0300);
        tick();
        check("pre_reset_fetching", 32'(mem_rd), 1);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
